// File: rtl/mem_bus_master_pkg.sv
// rtl/mem_bus_master_pkg.sv - shared encodings for the memory bus master
package mem_bus_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  localparam logic MEM = 1'b0;
  localparam logic IO  = 1'b1;

endpackage

// File: rtl/mem_bus_master_rr_arb2.sv
// rtl/mem_bus_master_rr_arb2.sv - two-way round-robin arbiter remembering the last winner
module rr_arb2
  import mem_bus_master_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_grant;

  assign gnt_valid = |req;

  // On a tie the client that did not win last time goes first.
  always_comb begin
    gnt_id = FETCH;
    if (req[DATA] && req[FETCH]) begin
      gnt_id = ~last_grant;
    end else if (req[DATA]) begin
      gnt_id = DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= FETCH;
    end else if (update && gnt_valid) begin
      last_grant <= gnt_id;
    end
  end

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - arbitrates fetch and data clients onto the memory/IO export bus
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int DW  = 16,
  parameter int AW  = 16,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_io,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          bus_en,
  output logic          bus_rw,
  output logic          bus_memio,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  output logic          busy
);

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t        state, state_n;
  logic          grant, grant_n;
  logic [3:0]    cnt, cnt_n;
  logic          bus_en_n, bus_rw_n, bus_memio_n;
  logic [AW-1:0] bus_addr_n;
  logic [DW-1:0] bus_wdata_n;
  logic          if_ack_n, d_ack_n, busy_n;
  logic [DW-1:0] if_rdata_n, d_rdata_n;
  logic          arb_update;
  logic          gnt_valid, gnt_id;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({d_req, if_req}),
    .update    (arb_update),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    cnt_n       = cnt;
    bus_en_n    = bus_en;
    bus_rw_n    = bus_rw;
    bus_memio_n = bus_memio;
    bus_addr_n  = bus_addr;
    bus_wdata_n = bus_wdata;
    if_ack_n    = 1'b0;
    d_ack_n     = 1'b0;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
    arb_update  = 1'b0;

    case (state)
      IDLE: begin
        if (gnt_valid) begin
          arb_update = 1'b1;
          state_n    = ACCESS;
          grant_n    = gnt_id;
          cnt_n      = 4'd1;
          bus_en_n   = 1'b1;
          if (gnt_id == DATA) begin
            bus_rw_n    = d_we;
            bus_memio_n = d_io;
            bus_addr_n  = d_addr;
            bus_wdata_n = d_wdata;
          end else begin
            bus_rw_n    = RD;
            bus_memio_n = MEM;
            bus_addr_n  = if_addr;
            bus_wdata_n = '0;
          end
        end
      end
      ACCESS: begin
        if (cnt == LAT_CNT) begin
          bus_en_n = 1'b0;
          state_n  = RESP;
          if (grant == FETCH) begin
            if_ack_n   = 1'b1;
            if_rdata_n = bus_rdata;
          end else begin
            d_ack_n = 1'b1;
            // Writes leave the last read word in place.
            if (bus_rw == RD) begin
              d_rdata_n = bus_rdata;
            end
          end
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= FETCH;
      cnt       <= 4'd0;
      bus_en    <= 1'b0;
      bus_rw    <= 1'b0;
      bus_memio <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      cnt       <= cnt_n;
      bus_en    <= bus_en_n;
      bus_rw    <= bus_rw_n;
      bus_memio <= bus_memio_n;
      bus_addr  <= bus_addr_n;
      bus_wdata <= bus_wdata_n;
      if_ack    <= if_ack_n;
      d_ack     <= d_ack_n;
      if_rdata  <= if_rdata_n;
      d_rdata   <= d_rdata_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - scoreboard bench for mem_bus_master
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_req3;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        d_we, d_io;
  logic        if_ack, d_ack, bus_en, bus_rw, bus_memio, busy;
  logic [15:0] if_rdata, d_rdata, bus_addr, bus_wdata, bus_rdata;
  logic        if_ack3, d_ack3, bus_en3, bus_rw3, bus_memio3, busy3;
  logic [15:0] if_rdata3, d_rdata3, bus_addr3, bus_wdata3, bus_rdata3;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'h0000: rom = 16'hFFFF;
      16'h0010: rom = 16'h1234;
      16'h0020: rom = 16'hAAAA;
      16'h0030: rom = 16'h5555;
      16'h00F0: rom = 16'hBEEF;
      default:  rom = 16'hDEAD;
    endcase
  endfunction

  assign bus_rdata  = rom(bus_addr);
  assign bus_rdata3 = rom(bus_addr3);

  mem_bus_master #(.DW(16), .AW(16), .LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_io(d_io), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_en(bus_en), .bus_rw(bus_rw), .bus_memio(bus_memio), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .busy(busy)
  );

  mem_bus_master #(.DW(16), .AW(16), .LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(1'b0), .if_addr(16'h0000), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we), .d_io(d_io), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .bus_en(bus_en3), .bus_rw(bus_rw3), .bus_memio(bus_memio3), .bus_addr(bus_addr3),
    .bus_wdata(bus_wdata3), .bus_rdata(bus_rdata3), .busy(busy3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rw;
    logic        memio;
    logic [15:0] addr;
    logic [15:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        id;
    logic [15:0] if_rd;
    logic [15:0] d_rd;
  } ack_exp_t;

  bus_exp_t bus_q[$];
  ack_exp_t ack_q[$];

  // Monitor for the LAT=1 instance
  bus_exp_t be;
  ack_exp_t ae;
  logic     prev_en    = 1'b0;
  int       en_start   = 0;
  int       en_len     = 0;
  int       prev_start = 0;
  bit       have_prev  = 1'b0;
  bit       b2b        = 1'b0;

  always @(negedge clk) begin
    if (bus_en && !prev_en) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 1, 0);
      end else begin
        be = bus_q.pop_front();
        chk("bus_rw", bus_rw, be.rw);
        chk("bus_memio", bus_memio, be.memio);
        chk("bus_addr", bus_addr, be.addr);
        chk("bus_wdata", bus_wdata, be.wdata);
      end
      if (b2b && have_prev) chk("access_spacing", cyc - prev_start, 3);
      have_prev  = b2b;
      prev_start = cyc;
      en_start   = cyc;
      en_len     = 0;
    end
    if (bus_en) en_len++;
    if (!bus_en && prev_en) chk("bus_en_len", en_len, 1);
    prev_en = bus_en;

    if (if_ack || d_ack) begin
      if (if_ack && d_ack) chk("both_acks", 1, 0);
      if (ack_q.size() == 0) begin
        chk("ack_unexpected", 1, 0);
      end else begin
        ae = ack_q.pop_front();
        chk("ack_id", d_ack, ae.id);
        chk("if_rdata", if_rdata, ae.if_rd);
        chk("d_rdata", d_rdata, ae.d_rd);
        chk("ack_latency", cyc - en_start, 1);
      end
    end
  end

  task automatic data_op(input logic we, input logic io, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] if_e,
                         input logic [15:0] d_e);
    bit got;
    bus_q.push_back(bus_exp_t'{we, io, addr, wdata});
    ack_q.push_back(ack_exp_t'{1'b1, if_e, d_e});
    @(posedge clk); #1;
    d_we = we; d_io = io; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (d_ack) got = 1'b1;
    end
    if (!got) chk("d_ack_timeout", 0, 1);
    d_req = 1'b0;
  endtask

  task automatic fetch_op(input logic [15:0] addr, input logic [15:0] if_e,
                          input logic [15:0] d_e);
    bit got;
    bus_q.push_back(bus_exp_t'{1'b0, 1'b0, addr, 16'h0000});
    ack_q.push_back(ack_exp_t'{1'b0, if_e, d_e});
    @(posedge clk); #1;
    if_addr = addr; if_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (if_ack) got = 1'b1;
    end
    if (!got) chk("if_ack_timeout", 0, 1);
    if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int  nack;
    int  len;
    bit  got;

    rst_n = 1'b0;
    if_req = 1'b1; d_req = 1'b1; d_req3 = 1'b0;
    if_addr = 16'h0010;
    d_we = 1'b1; d_io = 1'b0; d_addr = 16'h0000; d_wdata = 16'hFFFF;

    // Reset with both requests high
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_bus_en", bus_en, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);

    // First tie after reset goes to data: write 0x0000 <= 0xFFFF
    bus_q.push_back(bus_exp_t'{1'b1, 1'b0, 16'h0000, 16'hFFFF});
    ack_q.push_back(ack_exp_t'{1'b1, 16'h0000, 16'h0000});
    rst_n = 1'b1;
    #1;
    chk("release_bus_en", bus_en, 0);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (d_ack) got = 1'b1;
    end
    if (!got) chk("first_ack_timeout", 0, 1);
    if_req = 1'b0; d_req = 1'b0;

    data_op(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    fetch_op(16'h0010, 16'h1234, 16'hFFFF);

    // Both held for three back-to-back accesses: DATA, FETCH, DATA
    bus_q.push_back(bus_exp_t'{1'b0, 1'b0, 16'h0030, 16'h0000});
    ack_q.push_back(ack_exp_t'{1'b1, 16'h1234, 16'h5555});
    bus_q.push_back(bus_exp_t'{1'b0, 1'b0, 16'h0020, 16'h0000});
    ack_q.push_back(ack_exp_t'{1'b0, 16'hAAAA, 16'h5555});
    bus_q.push_back(bus_exp_t'{1'b0, 1'b0, 16'h0030, 16'h0000});
    ack_q.push_back(ack_exp_t'{1'b1, 16'hAAAA, 16'h5555});
    b2b = 1'b1;
    @(posedge clk); #1;
    if_addr = 16'h0020;
    d_we = 1'b0; d_io = 1'b0; d_addr = 16'h0030; d_wdata = 16'h0000;
    if_req = 1'b1; d_req = 1'b1;
    nack = 0;
    for (int i = 0; i < 60 && nack < 3; i++) begin
      @(negedge clk);
      if (if_ack || d_ack) nack++;
    end
    chk("tie_ack_count", nack, 3);
    if_req = 1'b0; d_req = 1'b0;
    b2b = 1'b0;
    repeat (4) @(negedge clk);
    chk("tie_idle", busy, 0);

    // IO read on the LAT=3 instance
    @(posedge clk); #1;
    d_we = 1'b0; d_io = 1'b1; d_addr = 16'h00F0; d_wdata = 16'h0000; d_req3 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus_en3) got = 1'b1;
    end
    if (!got) chk("io_en_timeout", 0, 1);
    chk("io_memio", bus_memio3, 1);
    chk("io_rw", bus_rw3, 0);
    chk("io_addr", bus_addr3, 16'h00F0);
    len = 0;
    while (bus_en3 && len < 20) begin
      chk("io_no_early_ack", d_ack3, 0);
      len++;
      @(negedge clk);
    end
    chk("io_en_len", len, 3);
    chk("io_d_ack", d_ack3, 1);
    chk("io_d_rdata", d_rdata3, 16'hBEEF);
    d_req3 = 1'b0;
    @(negedge clk);
    chk("io_ack_pulse", d_ack3, 0);
    chk("io_if_ack", if_ack3, 0);

    // Reset pulse mid-access aborts without an ack
    bus_q.push_back(bus_exp_t'{1'b1, 1'b0, 16'h0040, 16'h1111});
    @(posedge clk); #1;
    d_we = 1'b1; d_io = 1'b0; d_addr = 16'h0040; d_wdata = 16'h1111; d_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus_en) got = 1'b1;
    end
    if (!got) chk("abort_en_timeout", 0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_bus_en", bus_en, 0);
    chk("abort_busy", busy, 0);
    d_req = 1'b0;
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_en", bus_en, 0);
    chk("abort_d_rdata", d_rdata, 0);

    chk("bus_q_empty", bus_q.size(), 0);
    chk("ack_q_empty", ack_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
